fpu_op_sequencer: RTL and testbench

//  Initiator side of the fixed-point unit (FPU) datapath.
//  - Accepts operation requests on a valid/ready interface.
//  - Drives the FPU operand/select ports and waits the FPU latency.
//  - Captures the 40-bit FPU result and narrows it to 32 bits with unsigned saturation.
//  - Returns the result on a valid/ready response interface.

---
 rtl/fpu_op_sequencer.sv | 161 ++++++++++++++++
 tb/tb_fpu_op_sequencer.sv | 361 ++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fpu_op_sequencer.sv
// Initiator for the fixed-point unit: issues one operation at a time, waits the FPU
// latency, saturates the 40-bit result to unsigned 32 bits and returns it on a valid/ready port.

package fpu_package;
  typedef enum logic [3:0] {
    FPU_OP_ADD = 4'h0,
    FPU_OP_SUB = 4'h1
  } fpu_op_e;
endpackage

module fpu_op_sequencer
  import fpu_package::*;
#(
  parameter int FPU_LAT = 1,
  parameter int CNT_W   = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             req_valid,
  output logic             req_ready,
  input  logic [31:0]      req_a,
  input  logic [31:0]      req_b,
  input  logic [3:0]       req_op,
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic [31:0]      rsp_data,
  output logic [39:0]      rsp_raw,
  output logic             rsp_ovf,
  output logic             rsp_unf,
  output logic [31:0]      fpu_in1,
  output logic [31:0]      fpu_in2,
  output logic [3:0]       fpu_sel,
  input  logic [39:0]      fpu_out,
  output logic [CNT_W-1:0] sat_count
);

  localparam int WCNT_W = (FPU_LAT > 1) ? $clog2(FPU_LAT) : 1;

  typedef enum logic [1:0] {
    S_IDLE,
    S_WAIT,
    S_RESP
  } state_e;

  state_e              state_q;
  logic [WCNT_W-1:0]   wait_cnt_q;
  logic                req_ready_q;
  logic                rsp_valid_q;
  logic [31:0]         rsp_data_q;
  logic [39:0]         rsp_raw_q;
  logic                rsp_ovf_q;
  logic                rsp_unf_q;
  logic [31:0]         fpu_in1_q;
  logic [31:0]         fpu_in2_q;
  logic [3:0]          fpu_sel_q;
  logic [CNT_W-1:0]    sat_count_q;

  logic [31:0]         rsp_data_d;
  logic                rsp_ovf_d;
  logic                rsp_unf_d;
  logic [CNT_W-1:0]    sat_count_d;
  logic                req_hs;
  logic                rsp_hs;

  // Unsigned narrowing of the two's-complement FPU result.
  always_comb begin
    // NOTE: every always_comb output gets a default first, so no latch can be inferred.
    rsp_data_d = fpu_out[31:0];
    rsp_ovf_d  = 1'b0;
    rsp_unf_d  = 1'b0;
    if (fpu_out[39]) begin
      rsp_data_d = '0;
      rsp_unf_d  = 1'b1;
    end else if (fpu_out[39:32] != 8'h00) begin
      rsp_data_d = '1;
      rsp_ovf_d  = 1'b1;
    end
  end

  assign req_hs = (state_q == S_IDLE) && req_valid && req_ready_q;
  assign rsp_hs = (state_q == S_RESP) && rsp_ready;

  // Counts saturated responses; sticks at all-ones instead of wrapping.
  always_comb begin
    sat_count_d = sat_count_q;
    if (rsp_hs && (rsp_ovf_q || rsp_unf_q) && (sat_count_q != '1)) begin
      sat_count_d = sat_count_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    // NOTE: sequential state is written with non-blocking assignments only, so every
    // register samples pre-edge values regardless of statement order.
    if (rst) begin
      state_q     <= S_IDLE;
      wait_cnt_q  <= '0;
      req_ready_q <= 1'b0;
      rsp_valid_q <= 1'b0;
      rsp_data_q  <= '0;
      rsp_raw_q   <= '0;
      rsp_ovf_q   <= 1'b0;
      rsp_unf_q   <= 1'b0;
      fpu_in1_q   <= '0;
      fpu_in2_q   <= '0;
      fpu_sel_q   <= '0;
      sat_count_q <= '0;
    end else begin
      sat_count_q <= sat_count_d;
      unique case (state_q)
        S_IDLE: begin
          // req_ready rises one cycle after reset release, so the first IDLE cycle never accepts.
          req_ready_q <= 1'b1;
          if (req_hs) begin
            fpu_in1_q   <= req_a;
            fpu_in2_q   <= req_b;
            fpu_sel_q   <= req_op;
            wait_cnt_q  <= WCNT_W'(FPU_LAT - 1);
            req_ready_q <= 1'b0;
            state_q     <= S_WAIT;
          end
        end
        S_WAIT: begin
          if (wait_cnt_q == '0) begin
            rsp_raw_q   <= fpu_out;
            rsp_data_q  <= rsp_data_d;
            rsp_ovf_q   <= rsp_ovf_d;
            rsp_unf_q   <= rsp_unf_d;
            rsp_valid_q <= 1'b1;
            state_q     <= S_RESP;
          end else begin
            wait_cnt_q <= wait_cnt_q - WCNT_W'(1);
          end
        end
        S_RESP: begin
          if (rsp_ready) begin
            rsp_valid_q <= 1'b0;
            req_ready_q <= 1'b1;
            state_q     <= S_IDLE;
          end
        end
        default: begin
          rsp_valid_q <= 1'b0;
          req_ready_q <= 1'b0;
          state_q     <= S_IDLE;
        end
      endcase
    end
  end

  assign req_ready = req_ready_q;
  assign rsp_valid = rsp_valid_q;
  assign rsp_data  = rsp_data_q;
  assign rsp_raw   = rsp_raw_q;
  assign rsp_ovf   = rsp_ovf_q;
  assign rsp_unf   = rsp_unf_q;
  assign fpu_in1   = fpu_in1_q;
  assign fpu_in2   = fpu_in2_q;
  assign fpu_sel   = fpu_sel_q;
  assign sat_count = sat_count_q;

endmodule

// File: tb/tb_fpu_op_sequencer.sv
// Bench for fpu_op_sequencer: a 1-cycle FPU instance for the main checks and a
// 3-cycle, 2-bit-counter instance for abort and counter-limit checks, both behind FPU models.

module tb_fpu_op_sequencer;
  import fpu_package::*;

  typedef struct packed {
    logic [31:0] data;
    logic [39:0] raw;
    logic        ovf;
    logic        unf;
  } rsp_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_err = 0;
  rsp_t sb[$];
  rsp_t sb3[$];

  // Instance A: FPU_LAT=1, CNT_W=16
  logic        rst, req_valid, req_ready, rsp_valid, rsp_ready, rsp_ovf, rsp_unf;
  logic [31:0] req_a, req_b, rsp_data, fpu_in1, fpu_in2;
  logic [3:0]  req_op, fpu_sel;
  logic [39:0] rsp_raw, fpu_out;
  logic [15:0] sat_count;
  logic        fpu_corrupt = 1'b0;

  // Instance B: FPU_LAT=3, CNT_W=2
  logic        rst_3, req_valid_3, req_ready_3, rsp_valid_3, rsp_ready_3, rsp_ovf_3, rsp_unf_3;
  logic [31:0] req_a_3, req_b_3, rsp_data_3, fpu_in1_3, fpu_in2_3;
  logic [3:0]  req_op_3, fpu_sel_3;
  logic [39:0] rsp_raw_3, fpu_out_3, fpu_s1_3, fpu_s2_3;
  logic [1:0]  sat_count_3;

  fpu_op_sequencer #(.FPU_LAT(1), .CNT_W(16)) u_dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready),
    .req_a(req_a), .req_b(req_b), .req_op(req_op),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data), .rsp_raw(rsp_raw),
    .rsp_ovf(rsp_ovf), .rsp_unf(rsp_unf), .fpu_in1(fpu_in1), .fpu_in2(fpu_in2),
    .fpu_sel(fpu_sel), .fpu_out(fpu_out), .sat_count(sat_count)
  );

  fpu_op_sequencer #(.FPU_LAT(3), .CNT_W(2)) u_dut_3 (
    .clk(clk), .rst(rst_3), .req_valid(req_valid_3), .req_ready(req_ready_3),
    .req_a(req_a_3), .req_b(req_b_3), .req_op(req_op_3),
    .rsp_valid(rsp_valid_3), .rsp_ready(rsp_ready_3), .rsp_data(rsp_data_3), .rsp_raw(rsp_raw_3),
    .rsp_ovf(rsp_ovf_3), .rsp_unf(rsp_unf_3), .fpu_in1(fpu_in1_3), .fpu_in2(fpu_in2_3),
    .fpu_sel(fpu_sel_3), .fpu_out(fpu_out_3), .sat_count(sat_count_3)
  );

  function automatic logic [39:0] fpu_calc(input logic [31:0] a, input logic [31:0] b,
                                           input logic [3:0] sel);
    if (sel == FPU_OP_ADD) return {8'h00, a} + {8'h00, b};
    return {8'h00, a} - {8'h00, b};
  endfunction

  function automatic rsp_t model(input logic [31:0] a, input logic [31:0] b,
                                 input logic [3:0] op);
    rsp_t r;
    r.raw = fpu_calc(a, b, op);
    r.ovf = 1'b0;
    r.unf = 1'b0;
    r.data = r.raw[31:0];
    if (r.raw[39]) begin
      r.unf = 1'b1;
      r.data = 32'h0000_0000;
    end else if (r.raw[38:32] != 7'd0) begin
      r.ovf = 1'b1;
      r.data = 32'hFFFF_FFFF;
    end
    return r;
  endfunction

  // Instance A's FPU answers within the cycle; corrupt mode drives junk to prove it is ignored.
  assign fpu_out = fpu_corrupt ? 40'hA5_5A5A_A5A5 : fpu_calc(fpu_in1, fpu_in2, fpu_sel);

  // Instance B's FPU has two internal stages, so its output is stale until the capture cycle.
  always @(posedge clk) begin
    fpu_s1_3 <= fpu_calc(fpu_in1_3, fpu_in2_3, fpu_sel_3);
    fpu_s2_3 <= fpu_s1_3;
  end
  assign fpu_out_3 = fpu_s2_3;

  rsp_t obs, obs_3;
  assign obs   = {rsp_data, rsp_raw, rsp_ovf, rsp_unf};
  assign obs_3 = {rsp_data_3, rsp_raw_3, rsp_ovf_3, rsp_unf_3};

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Drivers: present one request, return 1ns after its handshake edge.
  task automatic issue(input logic [31:0] a, input logic [31:0] b, input logic [3:0] op);
    int t = 0;
    while (!req_ready && t < 20) begin tick(); t++; end
    if (!req_ready) begin
      n_err++;
      $display("FAIL issue_timeout: req_ready=%b required 1", req_ready);
    end
    req_valid = 1'b1; req_a = a; req_b = b; req_op = op;
    sb.push_back(model(a, b, op));
    tick();
    req_valid = 1'b0;
  endtask

  task automatic issue_3(input logic [31:0] a, input logic [31:0] b, input logic [3:0] op);
    int t = 0;
    while (!req_ready_3 && t < 20) begin tick(); t++; end
    if (!req_ready_3) begin
      n_err++;
      $display("FAIL issue3_timeout: req_ready=%b required 1", req_ready_3);
    end
    req_valid_3 = 1'b1; req_a_3 = a; req_b_3 = b; req_op_3 = op;
    sb3.push_back(model(a, b, op));
    tick();
    req_valid_3 = 1'b0;
  endtask

  // Edges after the handshake edge until rsp_valid is visible; the consumer sees it one edge later.
  task automatic wait_rsp(output int edges);
    edges = 0;
    while (!rsp_valid && edges < 20) begin tick(); edges++; end
  endtask

  task automatic wait_rsp_3(output int edges);
    edges = 0;
    while (!rsp_valid_3 && edges < 20) begin tick(); edges++; end
  endtask

  task automatic test_reset();
    rst = 1'b1; req_valid = 1'b1; req_a = 32'h1234_5678; req_b = 32'h1; req_op = FPU_OP_ADD;
    rsp_ready = 1'b0;
    rst_3 = 1'b1; req_valid_3 = 1'b1; req_a_3 = 32'h7; req_b_3 = 32'h3; req_op_3 = FPU_OP_SUB;
    rsp_ready_3 = 1'b0;
    tick(); tick();
    n_cmp++;
    if ({req_ready, rsp_valid, obs, fpu_in1, fpu_in2, fpu_sel, sat_count} !== '0) begin
      n_err++;
      $display("FAIL reset_outputs: ready=%b valid=%b rsp=%h in1=%h in2=%h sel=%h cnt=%0d required all 0",
               req_ready, rsp_valid, obs, fpu_in1, fpu_in2, fpu_sel, sat_count);
    end
    n_cmp++;
    if ({req_ready_3, rsp_valid_3, obs_3, fpu_in1_3, fpu_in2_3, fpu_sel_3, sat_count_3} !== '0) begin
      n_err++;
      $display("FAIL reset_outputs_3: ready=%b valid=%b rsp=%h cnt=%0d required all 0",
               req_ready_3, rsp_valid_3, obs_3, sat_count_3);
    end
    rst = 1'b0; req_valid = 1'b0; rst_3 = 1'b0; req_valid_3 = 1'b0;
    tick();
    n_cmp++;
    if (req_ready !== 1'b1 || req_ready_3 !== 1'b1) begin
      n_err++;
      $display("FAIL reset_ready_after: ready=%b ready3=%b required 1 1", req_ready, req_ready_3);
    end
    for (int i = 0; i < 3; i++) begin
      tick();
      n_cmp++;
      if (rsp_valid !== 1'b0 || rsp_valid_3 !== 1'b0 || fpu_in1 !== 32'd0) begin
        n_err++;
        $display("FAIL reset_no_response: valid=%b valid3=%b in1=%h required 0 0 0",
                 rsp_valid, rsp_valid_3, fpu_in1);
      end
    end
  endtask

  // One full transaction on instance A with latency, payload and counter checks.
  task automatic run_op(input string name, input logic [31:0] a, input logic [31:0] b,
                        input logic [3:0] op, input int exp_cnt);
    int e;
    rsp_t exp;
    issue(a, b, op);
    wait_rsp(e);
    n_cmp++;
    if (e + 1 != 2) begin
      n_err++;
      $display("FAIL %s_latency: got %0d cycles required 2", name, e + 1);
    end
    exp = sb.pop_front();
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s_rsp: data=%h raw=%h ovf=%b unf=%b required data=%h raw=%h ovf=%b unf=%b",
               name, obs.data, obs.raw, obs.ovf, obs.unf, exp.data, exp.raw, exp.ovf, exp.unf);
    end
    rsp_ready = 1'b1;
    tick();
    rsp_ready = 1'b0;
    n_cmp++;
    if (rsp_valid !== 1'b0 || req_ready !== 1'b1 || sat_count !== 16'(exp_cnt)) begin
      n_err++;
      $display("FAIL %s_after_hs: valid=%b ready=%b cnt=%0d required 0 1 %0d",
               name, rsp_valid, req_ready, sat_count, exp_cnt);
    end
  endtask

  task automatic test_add();
    run_op("add", 32'h0001_0000, 32'h0002_8000, FPU_OP_ADD, 0);
    n_cmp++;
    if (rsp_data !== 32'h0003_8000 || rsp_ovf !== 1'b0 || rsp_unf !== 1'b0) begin
      n_err++;
      $display("FAIL add_value: data=%h ovf=%b unf=%b required 00038000 0 0", rsp_data, rsp_ovf, rsp_unf);
    end
  endtask

  task automatic test_overflow();
    run_op("ovf", 32'hFFFF_FFFF, 32'hFFFF_FFFF, FPU_OP_ADD, 1);
    n_cmp++;
    if (rsp_raw !== 40'h01_FFFF_FFFE || rsp_data !== 32'hFFFF_FFFF || rsp_ovf !== 1'b1) begin
      n_err++;
      $display("FAIL ovf_value: raw=%h data=%h ovf=%b required 01fffffffe ffffffff 1",
               rsp_raw, rsp_data, rsp_ovf);
    end
  endtask

  task automatic test_underflow();
    run_op("unf", 32'd5, 32'd7, FPU_OP_SUB, 2);
    n_cmp++;
    if (rsp_raw !== 40'hFF_FFFF_FFFE || rsp_data !== 32'd0 || rsp_unf !== 1'b1 || rsp_ovf !== 1'b0) begin
      n_err++;
      $display("FAIL unf_value: raw=%h data=%h unf=%b ovf=%b required fffffffffe 0 1 0",
               rsp_raw, rsp_data, rsp_unf, rsp_ovf);
    end
    run_op("sub_plain", 32'h8000_0000, 32'h0000_0001, FPU_OP_SUB, 2);
  endtask

  task automatic test_backpressure();
    int e;
    rsp_t exp, snap;
    issue(32'h0000_1111, 32'h0000_2222, FPU_OP_ADD);
    wait_rsp(e);
    exp = sb.pop_front();
    snap = obs;
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL bp_first_rsp: got %h required %h", obs, exp);
    end
    req_valid = 1'b1; req_a = 32'h0000_0100; req_b = 32'h0000_0200; req_op = FPU_OP_SUB;
    sb.push_back(model(32'h0000_0100, 32'h0000_0200, FPU_OP_SUB));
    fpu_corrupt = 1'b1;
    for (int i = 0; i < 5; i++) begin
      tick();
      n_cmp++;
      if (obs !== snap || rsp_valid !== 1'b1 || req_ready !== 1'b0 || fpu_in1 !== 32'h0000_1111) begin
        n_err++;
        $display("FAIL bp_hold_%0d: rsp=%h valid=%b ready=%b in1=%h required %h 1 0 00001111",
                 i, obs, rsp_valid, req_ready, fpu_in1, snap);
      end
    end
    fpu_corrupt = 1'b0;
    rsp_ready = 1'b1;
    tick();
    rsp_ready = 1'b0;
    n_cmp++;
    if (rsp_valid !== 1'b0 || req_ready !== 1'b1 || fpu_in1 !== 32'h0000_1111) begin
      n_err++;
      $display("FAIL bp_release: valid=%b ready=%b in1=%h required 0 1 00001111", rsp_valid, req_ready, fpu_in1);
    end
    tick();
    req_valid = 1'b0;
    n_cmp++;
    if (fpu_in1 !== 32'h0000_0100 || fpu_sel !== FPU_OP_SUB) begin
      n_err++;
      $display("FAIL bp_second_accept: in1=%h sel=%h required 00000100 1", fpu_in1, fpu_sel);
    end
    wait_rsp(e);
    exp = sb.pop_front();
    n_cmp++;
    if (e + 1 != 2 || obs !== exp) begin
      n_err++;
      $display("FAIL bp_second_rsp: lat=%0d rsp=%h required 2 %h", e + 1, obs, exp);
    end
    rsp_ready = 1'b1;
    tick();
    rsp_ready = 1'b0;
  endtask

  task automatic test_sat_limit();
    int e;
    rsp_t exp;
    for (int k = 1; k <= 4; k++) begin
      issue_3(32'hFFFF_FFFF, 32'd1, FPU_OP_ADD);
      wait_rsp_3(e);
      exp = sb3.pop_front();
      n_cmp++;
      if (obs_3 !== exp) begin
        n_err++;
        $display("FAIL sat_rsp_%0d: got %h required %h", k, obs_3, exp);
      end
      rsp_ready_3 = 1'b1;
      tick();
      rsp_ready_3 = 1'b0;
      n_cmp++;
      if (sat_count_3 !== 2'((k > 3) ? 3 : k)) begin
        n_err++;
        $display("FAIL sat_count_%0d: got %0d required %0d", k, sat_count_3, (k > 3) ? 3 : k);
      end
    end
  endtask

  task automatic test_abort();
    int e;
    rsp_t exp;
    issue_3(32'd1, 32'd2, FPU_OP_ADD);
    rst_3 = 1'b1;
    tick();
    rst_3 = 1'b0;
    void'(sb3.pop_front());
    n_cmp++;
    if (rsp_valid_3 !== 1'b0 || sat_count_3 !== 2'd0 || req_ready_3 !== 1'b0) begin
      n_err++;
      $display("FAIL abort_state: valid=%b cnt=%0d ready=%b required 0 0 0", rsp_valid_3, sat_count_3, req_ready_3);
    end
    for (int i = 0; i < 5; i++) begin
      tick();
      n_cmp++;
      if (rsp_valid_3 !== 1'b0) begin
        n_err++;
        $display("FAIL abort_no_rsp_%0d: valid=%b required 0", i, rsp_valid_3);
      end
    end
    // Consumer already ready before the response exists; it must still appear intact.
    rsp_ready_3 = 1'b1;
    issue_3(32'h0000_0100, 32'h0000_0023, FPU_OP_SUB);
    wait_rsp_3(e);
    exp = sb3.pop_front();
    n_cmp++;
    if (e + 1 != 4) begin
      n_err++;
      $display("FAIL abort_next_latency: got %0d cycles required 4", e + 1);
    end
    n_cmp++;
    if (obs_3 !== exp) begin
      n_err++;
      $display("FAIL abort_next_rsp: got %h required %h", obs_3, exp);
    end
    tick();
    rsp_ready_3 = 1'b0;
    n_cmp++;
    if (rsp_valid_3 !== 1'b0 || req_ready_3 !== 1'b1) begin
      n_err++;
      $display("FAIL abort_next_done: valid=%b ready=%b required 0 1", rsp_valid_3, req_ready_3);
    end
  endtask

  initial begin
    test_reset();
    test_add();
    test_overflow();
    test_underflow();
    test_backpressure();
    test_sat_limit();
    test_abort();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
